// File: rtl/address_arbiter.sv
// address_arbiter: registered N_CH-way address arbiter for the sample RAM port.
// Fixed-priority (RR=0) or round-robin (RR=1) arbitration; MAX_HOLD bounds
// how long one channel keeps the grant while others are waiting.
// Build option: ADDRESS_ARBITER_HOLD_LAST_EN -- when defined, adOut keeps the
// last granted address while idle; otherwise idle adOut tracks channel 0.

// Per-channel slice: eligibility for arbitration and an AND-mask of the
// channel's address so the top can OR-reduce to the selected address.
module address_arbiter_lane #(
  parameter int AW  = 15,
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic          req_bit,
  input  logic          mask_bit,
  input  logic [AW-1:0] ad_slice,
  input  logic [IW-1:0] sel,
  output logic          elig,
  output logic [AW-1:0] ad_masked
);

  // channel competes unless it is the holder being forced off
  assign elig      = req_bit & ~mask_bit;
  assign ad_masked = (sel == IW'(IDX)) ? ad_slice : '0;

endmodule

module address_arbiter #(
  parameter  int N_CH     = 4,
  parameter  int AW       = 15,
  parameter  int RR       = 0,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH),
  localparam int HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*AW-1:0] ad,
  output logic [AW-1:0]      adOut,
  output logic               en,
  output logic [N_CH-1:0]    grant,
  output logic [IW-1:0]      gnt_idx
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]                 state;
  logic [HW-1:0]              hold_cnt;
  logic [IW-1:0]              last;

  logic                       cur_req;
  logic                       other_req;
  logic                       hold_ok;
  logic                       stay;
  logic [N_CH-1:0]            mask;
  logic [N_CH-1:0]            elig;
  logic                       win_vld;
  logic [IW-1:0]              win_idx;
  logic                       nxt_vld;
  logic [IW-1:0]              nxt_idx;
  logic [N_CH-1:0]            nxt_oh;
  logic [N_CH-1:0][AW-1:0]    ad_masked;
  logic [AW-1:0]              ad_sel;

  // grant register is one-hot of the current holder (zero when idle)
  assign cur_req   = |(req & grant);
  assign other_req = |(req & ~grant);
  assign hold_ok   = (MAX_HOLD == 0) || (hold_cnt < HW'(MAX_HOLD)) || !other_req;
  assign stay      = (state == S_GRANT) && cur_req && hold_ok;
  // the holder is excluded only when it is being forced off by the hold limit
  assign mask      = cur_req ? grant : '0;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      address_arbiter_lane #(.AW(AW), .IW(IW), .IDX(g)) u_lane (
        .req_bit   (req[g]),
        .mask_bit  (mask[g]),
        .ad_slice  (ad[g*AW +: AW]),
        .sel       (nxt_idx),
        .elig      (elig[g]),
        .ad_masked (ad_masked[g])
      );
    end
  endgenerate

  // pick a winner among eligible channels: lowest index, or rotate from last+1
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (RR != 0) begin
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (int'(last) + k) % N_CH;
        if (!win_vld && elig[c]) begin
          win_vld = 1'b1;
          win_idx = IW'(c);
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

  // next owner and its address (OR of masked lane addresses)
  always_comb begin
    nxt_vld = stay | win_vld;
    nxt_idx = stay ? gnt_idx : win_idx;
    nxt_oh  = '0;
    nxt_oh[nxt_idx] = 1'b1;
    ad_sel  = '0;
    for (int i = 0; i < N_CH; i++) ad_sel = ad_sel | ad_masked[i];
  end

  // FSM, hold counter, round-robin pointer and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      last     <= IW'(N_CH - 1);
      adOut    <= '0;
      en       <= 1'b0;
      grant    <= '0;
      gnt_idx  <= '0;
    end else if (nxt_vld) begin
      state   <= S_GRANT;
      en      <= 1'b1;
      grant   <= nxt_oh;
      gnt_idx <= nxt_idx;
      adOut   <= ad_sel;
      if (stay) begin
        if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD))
          hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= HW'(1);
        last     <= win_idx;
      end
    end else begin
      state    <= S_IDLE;
      en       <= 1'b0;
      grant    <= '0;
      hold_cnt <= '0;
`ifdef ADDRESS_ARBITER_HOLD_LAST_EN
      adOut    <= adOut;
`else
      adOut    <= ad[AW-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_address_arbiter.sv
// Bench for address_arbiter: three configurations share one stimulus stream
// and are compared each cycle against an owner/run-length reference model.
module tb_address_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int IW = 2;
  localparam int ND = 3;

  // per-instance configuration: RR mode and hold limit
  localparam int MRR[ND] = '{0, 1, 0};
  localparam int MMH[ND] = '{3, 1, 0};

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] ad = '0;

  logic [AW-1:0]   ado [ND];
  logic            eno [ND];
  logic [N-1:0]    gro [ND];
  logic [IW-1:0]   ixo [ND];

  int n_chk = 0;
  int n_pass = 0;

  // reference model state: owner (-1 idle), run length, RR pointer, address
  int            own [ND];
  int            cnt [ND];
  int            lst [ND];
  logic [AW-1:0] mad [ND];

  always #5 clock = ~clock;

  address_arbiter #(.N_CH(N), .AW(AW), .RR(0), .MAX_HOLD(3)) d0 (
    .clock(clock), .resetn(resetn), .req(req), .ad(ad),
    .adOut(ado[0]), .en(eno[0]), .grant(gro[0]), .gnt_idx(ixo[0]));
  address_arbiter #(.N_CH(N), .AW(AW), .RR(1), .MAX_HOLD(1)) d1 (
    .clock(clock), .resetn(resetn), .req(req), .ad(ad),
    .adOut(ado[1]), .en(eno[1]), .grant(gro[1]), .gnt_idx(ixo[1]));
  address_arbiter #(.N_CH(N), .AW(AW), .RR(0), .MAX_HOLD(0)) d2 (
    .clock(clock), .resetn(resetn), .req(req), .ad(ad),
    .adOut(ado[2]), .en(eno[2]), .grant(gro[2]), .gnt_idx(ixo[2]));

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] get_ad(input int c);
    return ad[c*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      own[k] = -1; cnt[k] = 0; lst[k] = N - 1; mad[k] = '0;
    end
  endtask

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      int  o;
      bit  cr;
      bit  oth;
      o   = own[k];
      cr  = (o >= 0) && req[o];
      oth = 0;
      for (int i = 0; i < N; i++) if (i != o && req[i]) oth = 1;
      if (cr && (MMH[k] == 0 || cnt[k] < MMH[k] || !oth)) begin
        if (cnt[k] < MMH[k]) cnt[k]++;
      end else begin
        int w;
        w = -1;
        for (int j = 0; j < N; j++) begin
          int c;
          c = (MRR[k] != 0) ? (lst[k] + 1 + j) % N : j;
          if (w < 0 && req[c] && !(cr && c == o)) w = c;
        end
        own[k] = w;
        if (w >= 0) begin cnt[k] = 1; lst[k] = w; end
      end
      if (own[k] >= 0) mad[k] = get_ad(own[k]);
      else begin
`ifndef ADDRESS_ARBITER_HOLD_LAST_EN
        mad[k] = get_ad(0);
`endif
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < ND; k++) begin
      logic [N-1:0] eg;
      eg = '0;
      if (own[k] >= 0) eg[own[k]] = 1'b1;
      chk($sformatf("%s.d%0d.en", ph, k), eno[k], own[k] >= 0);
      chk($sformatf("%s.d%0d.grant", ph, k), gro[k], eg);
      chk($sformatf("%s.d%0d.adOut", ph, k), ado[k], mad[k]);
      if (own[k] >= 0) chk($sformatf("%s.d%0d.idx", ph, k), ixo[k], own[k]);
    end
  endtask

  // one edge: model advances, DUT samples, outputs checked, back at negedge
  task automatic cyc(input string ph);
    model_step();
    @(posedge clock);
    #1 check_all(ph);
    @(negedge clock);
  endtask

  // asynchronous reset between edges while traffic is running
  task automatic mid_reset(input string ph);
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s.d%0d.en", ph, k), eno[k], 0);
      chk($sformatf("%s.d%0d.grant", ph, k), gro[k], 0);
      chk($sformatf("%s.d%0d.adOut", ph, k), ado[k], 0);
    end
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] a0;
    int seq_rr [5];
    int seq_h  [7];
    seq_rr = '{0, 1, 2, 3, 0};
    seq_h  = '{0, 0, 0, 1, 1, 1, 0};

    // reset held with all requests up
    model_reset();
    req = '1;
    for (int c = 0; c < N; c++) ad[c*AW +: AW] = AW'($urandom);
    repeat (3) @(posedge clock);
    #1 check_all("rst");
    @(negedge clock);
    resetn = 1'b1;
    a0 = get_ad(0);
    cyc("rel");
    chk("rel.grant0", gro[0], 4'b0001);
    chk("rel.ad0", ado[0], a0);

    // fixed priority, unlimited hold
    req = 4'b1100;
    ad[2*AW +: AW] = 15'h100;
    ad[3*AW +: AW] = 15'h200;
    for (int i = 0; i < 4; i++) begin
      cyc("fix");
      chk("fix.grant", gro[2], 4'b0100);
      chk("fix.ad", ado[2], 15'h100);
    end
    req = 4'b1000;
    cyc("fix2");
    chk("fix2.grant", gro[2], 4'b1000);
    chk("fix2.ad", ado[2], 15'h200);

    // async reset mid-grant, then round-robin from channel 0
    mid_reset("arst");
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc("rr");
      chk($sformatf("rr.idx%0d", i), ixo[1], seq_rr[i]);
    end

    // hold limit: 3 cycles per holder while the other channel waits
    req = '0;
    cyc("gap");
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      cyc("hold");
      chk($sformatf("hold.idx%0d", i), ixo[0], seq_h[i]);
    end
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc("solo");
      chk("solo.grant", gro[0], 4'b0001);
    end

    // idle address behaviour
    req = 4'b0010;
    ad[1*AW +: AW] = 15'h055;
    cyc("ia1");
    chk("ia1.ad", ado[0], 15'h055);
    req = '0;
    ad[0 +: AW] = 15'h7FF;
    cyc("ia2");
    chk("ia2.en", eno[0], 0);
`ifdef ADDRESS_ARBITER_HOLD_LAST_EN
    chk("ia2.ad", ado[0], 15'h055);
`else
    chk("ia2.ad", ado[0], 15'h7FF);
`endif

    // randomized traffic with sticky requests and occasional async reset
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(3) == 0) req[c] = ~req[c];
        if ($urandom_range(1) == 0) ad[c*AW +: AW] = AW'($urandom);
      end
      if ($urandom_range(99) == 0) mid_reset("rnd_rst");
      else cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
